gray_conv_arbiter: RTL and testbench

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

---
 rtl/gray_conv_pkg.sv | 8 +
 rtl/gray_conv_arbiter_if.sv | 28 ++
 rtl/gray_conv_arbiter_bin2gray.sv | 9 +
 rtl/gray_conv_arbiter.sv | 53 +++++
 tb/tb_gray_conv_arbiter.sv | 114 +++++++++++
 5 files changed

// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared types and constants for the gray_conv_arbiter slice.
// Holds the output-stage state encoding (EMPTY/FULL) and the default data width.
package gray_conv_pkg;
   localparam int GC_WIDTH = 4;
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL = 1'b1;
   typedef enum logic [0:0] {EMPTY = ST_EMPTY, FULL = ST_FULL} state_t;
endpackage

// File: rtl/gray_conv_arbiter_if.sv
// gray_conv_arbiter_if: request/result bundle for gray_conv_arbiter.
// Ports: req0/req1 valid/data/ready (two requesters), out_valid/out_data/out_id/out_ready
// (result consumer), out_parity only when GRAY_CONV_PARITY_EN is defined.
// Modports: master = requesters + consumer side, slave = the arbiter.
interface gray_conv_arbiter_if import gray_conv_pkg::*; #(parameter int WIDTH = GC_WIDTH);
   logic req0_valid;
   logic [WIDTH-1:0] req0_data;
   logic req0_ready;
   logic req1_valid;
   logic [WIDTH-1:0] req1_data;
   logic req1_ready;
   logic out_valid;
   logic [WIDTH-1:0] out_data;
   logic out_id;
   logic out_ready;
`ifdef GRAY_CONV_PARITY_EN
   logic out_parity;
   modport master (output req0_valid, req0_data, req1_valid, req1_data, out_ready,
                   input req0_ready, req1_ready, out_valid, out_data, out_id, out_parity);
   modport slave (input req0_valid, req0_data, req1_valid, req1_data, out_ready,
                  output req0_ready, req1_ready, out_valid, out_data, out_id, out_parity);
`else
   modport master (output req0_valid, req0_data, req1_valid, req1_data, out_ready,
                   input req0_ready, req1_ready, out_valid, out_data, out_id);
   modport slave (input req0_valid, req0_data, req1_valid, req1_data, out_ready,
                  output req0_ready, req1_ready, out_valid, out_data, out_id);
`endif
endinterface

// File: rtl/gray_conv_arbiter_bin2gray.sv
// bin2gray: purely combinational binary-to-Gray converter.
// Ports: bin (WIDTH binary in), gray (WIDTH Gray out).
module bin2gray #(parameter int WIDTH = 4) (
   input logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);
   // Each bit XORs with its upper neighbour; the MSB passes through (shift fills 0).
   assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: two requesters round-robin share one bin2gray into a single-entry output register.
// Ports: clk, rst (sync, active-high), bus (gray_conv_arbiter_if.slave: req0/req1 valid/data/ready,
// out_valid/out_data/out_id/out_ready). Optional macro GRAY_CONV_PARITY_EN adds registered out_parity.
module gray_conv_arbiter import gray_conv_pkg::*; #(parameter int WIDTH = GC_WIDTH) (
   input logic clk,
   input logic rst,
   gray_conv_arbiter_if.slave bus
);
   state_t state;
   logic last;
   logic free;
   logic pick1;
   logic xfer;
   logic id_q;
   logic [WIDTH-1:0] bin;
   logic [WIDTH-1:0] gray;
   logic [WIDTH-1:0] data_q;
   // Stage can accept when empty or when its current result drains this cycle.
   assign free = state == EMPTY || bus.out_ready;
   // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
   assign pick1 = bus.req1_valid && (!bus.req0_valid || !last);
   assign bus.req0_ready = !rst && free && bus.req0_valid && !pick1;
   assign bus.req1_ready = !rst && free && pick1;
   assign xfer = bus.req0_ready || bus.req1_ready;
   assign bin = pick1 ? bus.req1_data : bus.req0_data;
   bin2gray #(.WIDTH(WIDTH)) u_bin2gray (.bin(bin), .gray(gray));
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         data_q <= '0;
         id_q <= 1'b0;
         last <= 1'b1;
      end else if (xfer) begin
         state <= FULL;
         data_q <= gray;
         id_q <= pick1;
         last <= pick1;
      end else if (bus.out_ready) begin
         state <= EMPTY;
      end
   end
   assign bus.out_valid = state == FULL;
   assign bus.out_data = data_q;
   assign bus.out_id = id_q;
`ifdef GRAY_CONV_PARITY_EN
   logic par_q;
   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else if (xfer) par_q <= ^bin;
   end
   assign bus.out_parity = par_q;
`endif
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed self-checking bench for gray_conv_arbiter.
module tb_gray_conv_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0;
   int n_fail = 0;
   logic [3:0] gtab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
   gray_conv_arbiter_if #(.WIDTH(4)) bus ();
   gray_conv_arbiter #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic v0, input logic [3:0] d0, input logic v1, input logic [3:0] d1, input logic ordy);
      @(negedge clk);
      bus.req0_valid = v0;
      bus.req0_data = d0;
      bus.req1_valid = v1;
      bus.req1_data = d1;
      bus.out_ready = ordy;
      #1;
   endtask
   task automatic edge_out;
      @(posedge clk);
      #1;
   endtask
   task automatic check_out(input string tag, input logic v, input logic [3:0] d, input logic id);
      check({tag, ".valid"}, bus.out_valid, v);
      check({tag, ".data"}, bus.out_data, d);
      check({tag, ".id"}, bus.out_id, id);
   endtask
   initial begin
      bus.req0_valid = 1'b0;
      bus.req0_data = '0;
      bus.req1_valid = 1'b0;
      bus.req1_data = '0;
      bus.out_ready = 1'b0;
      edge_out();
      drive(1'b1, 4'd3, 1'b1, 4'd5, 1'b1);
      check("rst.rdy0", bus.req0_ready, 1'b0);
      check("rst.rdy1", bus.req1_ready, 1'b0);
      edge_out();
      check_out("rst", 1'b0, 4'd0, 1'b0);
      // Both valid every cycle: grants alternate 0,1,0,1 with no bubble.
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 4'b0001, 1'b1, 4'b0010, 1'b1);
         check($sformatf("rr%0d.rdy0", i), bus.req0_ready, i % 2 == 0);
         check($sformatf("rr%0d.rdy1", i), bus.req1_ready, i % 2 == 1);
         edge_out();
         check_out($sformatf("rr%0d", i), 1'b1, i % 2 == 0 ? 4'b0001 : 4'b0011, i % 2 == 1);
      end
      // Lone req0 with 0011, then drain to EMPTY.
      drive(1'b1, 4'b0011, 1'b0, 4'd0, 1'b1);
      check("single.rdy0", bus.req0_ready, 1'b1);
      edge_out();
      check_out("single", 1'b1, 4'b0010, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b1);
      edge_out();
      check("drain.valid", bus.out_valid, 1'b0);
      // Stall: result 0100 held while req1_data wiggles, then same-cycle drain and refill.
      drive(1'b1, 4'b0111, 1'b0, 4'd0, 1'b0);
      edge_out();
      check_out("load", 1'b1, 4'b0100, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 4'd0, 1'b1, 4'(i + 3), 1'b0);
         check($sformatf("stall%0d.rdy0", i), bus.req0_ready, 1'b0);
         check($sformatf("stall%0d.rdy1", i), bus.req1_ready, 1'b0);
         edge_out();
         check_out($sformatf("stall%0d", i), 1'b1, 4'b0100, 1'b0);
      end
      drive(1'b0, 4'd0, 1'b1, 4'b1010, 1'b1);
      check("refill.rdy1", bus.req1_ready, 1'b1);
      edge_out();
      check_out("refill", 1'b1, 4'b1111, 1'b1);
      // Full Gray sweep through requester 0.
      for (int v = 0; v < 16; v++) begin
         drive(1'b1, 4'(v), 1'b0, 4'd0, 1'b1);
         edge_out();
         check($sformatf("sweep%0d", v), bus.out_data, gtab[v]);
      end
      // Reset while FULL discards the result and re-arms the pointer toward req0.
      drive(1'b1, 4'b0101, 1'b0, 4'd0, 1'b0);
      edge_out();
      check("prerst.valid", bus.out_valid, 1'b1);
      rst = 1'b1;
      drive(1'b1, 4'b0001, 1'b1, 4'b0010, 1'b1);
      check("rstfull.rdy0", bus.req0_ready, 1'b0);
      check("rstfull.rdy1", bus.req1_ready, 1'b0);
      edge_out();
      check("rstfull.valid", bus.out_valid, 1'b0);
      rst = 1'b0;
      drive(1'b1, 4'b0001, 1'b1, 4'b0010, 1'b1);
      check("postrst.rdy0", bus.req0_ready, 1'b1);
      check("postrst.rdy1", bus.req1_ready, 1'b0);
      edge_out();
      check_out("postrst", 1'b1, 4'b0001, 1'b0);
`ifdef GRAY_CONV_PARITY_EN
      drive(1'b1, 4'b1011, 1'b0, 4'd0, 1'b1);
      edge_out();
      check("par1011", bus.out_parity, 1'b1);
      drive(1'b1, 4'b0110, 1'b0, 4'd0, 1'b1);
      edge_out();
      check("par0110", bus.out_parity, 1'b0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
